master_axis_if: RTL and testbench

- Transmit-side AXI4-Stream boundary for the trigger datapath; mirror of the receive-side slave interface.
- Takes beats from the internal module over a TDATA/TVALID/TLAST/MODULE_READY handshake and drives an AXI4-Stream master port.
- Unlike the receive side, both M_AXIS outputs and MODULE_READY are registered: a 2-entry skid buffer breaks the combinational TREADY path so the block closes timing.
- Also counts completed frames for status.

---
 rtl/axis_if_pkg.sv | 15 +
 rtl/master_axis_if_if.sv | 19 +
 rtl/master_axis_if.sv | 127 ++++++++++++
 tb/tb_master_axis_if.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/axis_if_pkg.sv
// Shared definitions for the AXI4-Stream boundary blocks of the trigger datapath.
// Holds the transmit-side buffer state encoding and the default bus width that
// the master and slave interfaces both use.
package axis_if_pkg;

  localparam int unsigned AXIS_DATA_WIDTH = 128;

  // Number of beats currently held by the transmit skid buffer.
  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_TWO   = 2'd2
  } skid_state_t;

endpackage

// File: rtl/master_axis_if_if.sv
// Generic stream handshake bundle: data, valid, last and ready.
// Used both for the internal beat source and for the external AXI4-Stream port.
//   master modport: drives tdata/tvalid/tlast, samples tready
//   slave  modport: samples tdata/tvalid/tlast, drives tready
interface master_axis_if_if
  import axis_if_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = AXIS_DATA_WIDTH
) ();

  logic [DATA_WIDTH-1:0] tdata;
  logic                  tvalid;
  logic                  tlast;
  logic                  tready;

  modport master (output tdata, output tvalid, output tlast, input tready);
  modport slave  (input tdata, input tvalid, input tlast, output tready);

endinterface

// File: rtl/master_axis_if.sv
// Transmit-side AXI4-Stream boundary. Accepts beats from the internal module and
// presents them on an AXI4-Stream master port through a 2-entry skid buffer, so
// every output (including the ready back upstream) comes straight from a flop.
// Also counts frames (TLAST beats) accepted downstream.
// Ports:
//   AXIS_ACLK     clock, rising edge
//   AXIS_ARESETN  asynchronous active-low reset
//   MODULE        slave side: TDATA/TVALID/TLAST in, MODULE_READY (tready) out
//   M_AXIS        master side: M_AXIS_TDATA/TVALID/TLAST out, M_AXIS_TREADY in
//   FRAME_COUNT   wrapping count of TLAST beats accepted downstream
module master_axis_if
  import axis_if_pkg::*;
#(
  parameter int unsigned M_AXIS_TDATA_WIDTH = AXIS_DATA_WIDTH,
  parameter int unsigned COUNT_WIDTH        = 16
) (
  input  logic                   AXIS_ACLK,
  input  logic                   AXIS_ARESETN,
  master_axis_if_if.slave        MODULE,
  master_axis_if_if.master       M_AXIS,
  output logic [COUNT_WIDTH-1:0] FRAME_COUNT
);

  skid_state_t r_state;
  skid_state_t w_state_next;

  logic [M_AXIS_TDATA_WIDTH-1:0] r_main_data;
  logic                          r_main_last;
  logic [M_AXIS_TDATA_WIDTH-1:0] r_skid_data;
  logic                          r_skid_last;
  logic                          r_tvalid;
  logic                          r_ready;
  logic [COUNT_WIDTH-1:0]        r_frame_count;

  logic w_in_fire;
  logic w_out_fire;
  logic w_load_main_in;
  logic w_load_main_skid;
  logic w_load_skid;
  logic w_tvalid_next;
  logic w_ready_next;

  assign w_in_fire  = MODULE.tvalid & r_ready;
  assign w_out_fire = r_tvalid & M_AXIS.tready;

  // State register plus the flops that sit directly on the outputs.
  // r_ready resets low and rises on the first edge after release, which makes
  // it double as the reset-done flop.
  always_ff @(posedge AXIS_ACLK or negedge AXIS_ARESETN) begin
    if (!AXIS_ARESETN) begin
      r_state       <= ST_EMPTY;
      r_tvalid      <= 1'b0;
      r_ready       <= 1'b0;
      r_main_data   <= '0;
      r_main_last   <= 1'b0;
      r_skid_data   <= '0;
      r_skid_last   <= 1'b0;
      r_frame_count <= '0;
    end else begin
      r_state  <= w_state_next;
      r_tvalid <= w_tvalid_next;
      r_ready  <= w_ready_next;
      if (w_load_main_in) begin
        r_main_data <= MODULE.tdata;
        r_main_last <= MODULE.tlast;
      end else if (w_load_main_skid) begin
        r_main_data <= r_skid_data;
        r_main_last <= r_skid_last;
      end
      if (w_load_skid) begin
        r_skid_data <= MODULE.tdata;
        r_skid_last <= MODULE.tlast;
      end
      if (w_out_fire && r_main_last) begin
        r_frame_count <= r_frame_count + 1'b1;
      end
    end
  end

  // Next-state and buffer load selection.
  always_comb begin
    w_state_next     = r_state;
    w_load_main_in   = 1'b0;
    w_load_main_skid = 1'b0;
    w_load_skid      = 1'b0;
    unique case (r_state)
      ST_EMPTY: begin
        if (w_in_fire) begin
          w_state_next   = ST_ONE;
          w_load_main_in = 1'b1;
        end
      end
      ST_ONE: begin
        if (w_in_fire && w_out_fire) begin
          w_load_main_in = 1'b1;
        end else if (w_in_fire) begin
          w_state_next = ST_TWO;
          w_load_skid  = 1'b1;
        end else if (w_out_fire) begin
          w_state_next = ST_EMPTY;
        end
      end
      ST_TWO: begin
        if (w_out_fire) begin
          w_state_next     = ST_ONE;
          w_load_main_skid = 1'b1;
        end
      end
      default: w_state_next = ST_EMPTY;
    endcase
  end

  // Output decode on the next state, so the output flops match the state flop.
  always_comb begin
    w_tvalid_next = 1'b0;
    w_ready_next  = 1'b0;
    w_tvalid_next = (w_state_next != ST_EMPTY);
    w_ready_next  = (w_state_next != ST_TWO);
  end

  assign MODULE.tready = r_ready;
  assign M_AXIS.tdata  = r_main_data;
  assign M_AXIS.tvalid = r_tvalid;
  assign M_AXIS.tlast  = r_main_last;
  assign FRAME_COUNT   = r_frame_count;

endmodule

// File: tb/tb_master_axis_if.sv
module tb_master_axis_if;
  import axis_if_pkg::*;

  localparam int unsigned W  = 128;
  localparam int unsigned CW = 4;
  localparam int unsigned STRESS_BEATS = 2000;

  logic          clk;
  logic          rst_n;
  logic [CW-1:0] fc;

  int unsigned n_chk  = 0;
  int unsigned n_pass = 0;

  master_axis_if_if #(.DATA_WIDTH(W)) mod_if ();
  master_axis_if_if #(.DATA_WIDTH(W)) m_if ();

  master_axis_if #(
    .M_AXIS_TDATA_WIDTH(W),
    .COUNT_WIDTH       (CW)
  ) dut (
    .AXIS_ACLK   (clk),
    .AXIS_ARESETN(rst_n),
    .MODULE      (mod_if),
    .M_AXIS      (m_if),
    .FRAME_COUNT (fc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [W:0] obs, input logic [W:0] exp);
    n_chk++;
    assert (obs === exp) begin
      n_pass++;
    end else begin
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [W-1:0] d, input logic l);
    mod_if.tvalid = v;
    mod_if.tdata  = d;
    mod_if.tlast  = l;
  endtask

  logic [W:0]  sb[$];
  logic [W:0]  exp_beat;
  logic [W:0]  hold_val;
  logic        in_f, out_f, hold;
  int unsigned sent, recv, lasts_out, cyc;

  initial begin
    rst_n = 1'b0;
    drive(1'b0, '0, 1'b0);
    m_if.tready = 1'b0;

    // Reset state
    #3;
    chk("rst_tvalid", 129'(m_if.tvalid), 129'(0));
    chk("rst_tlast",  129'(m_if.tlast),  129'(0));
    chk("rst_tdata",  129'(m_if.tdata),  129'(0));
    chk("rst_ready",  129'(mod_if.tready), 129'(0));
    chk("rst_fc",     129'(fc), 129'(0));
    #19;
    rst_n = 1'b1;
    #1;
    chk("ready_before_edge", 129'(mod_if.tready), 129'(0));
    step();
    chk("ready_after_edge", 129'(mod_if.tready), 129'(1));
    chk("idle_tvalid", 129'(m_if.tvalid), 129'(0));

    // Streaming, TREADY held high: one beat per cycle, 1-cycle latency.
    // Also exercises simultaneous in/out fires in state ONE.
    m_if.tready = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, W'(i), (i == 8));
      step();
      chk("stream_tvalid", 129'(m_if.tvalid), 129'(1));
      chk("stream_tdata",  129'(m_if.tdata),  129'(i));
      chk("stream_tlast",  129'(m_if.tlast),  129'(i == 8));
      chk("stream_ready",  129'(mod_if.tready), 129'(1));
    end
    drive(1'b0, '0, 1'b0);
    step();
    chk("stream_drain_tvalid", 129'(m_if.tvalid), 129'(0));
    chk("stream_fc", 129'(fc), 129'(1));

    // Backpressure
    m_if.tready = 1'b0;
    drive(1'b1, W'('hA), 1'b0);
    step();
    chk("bp_A_out",   129'(m_if.tdata), 129'('hA));
    chk("bp_A_ready", 129'(mod_if.tready), 129'(1));
    drive(1'b1, W'('hB), 1'b0);
    step();
    chk("bp_B_skid_out",   129'(m_if.tdata), 129'('hA));
    chk("bp_B_skid_ready", 129'(mod_if.tready), 129'(0));
    drive(1'b1, W'('hC), 1'b0);
    for (int i = 0; i < 2; i++) begin
      step();
      chk("bp_hold_tvalid", 129'(m_if.tvalid), 129'(1));
      chk("bp_hold_tdata",  129'(m_if.tdata),  129'('hA));
      chk("bp_hold_ready",  129'(mod_if.tready), 129'(0));
    end
    m_if.tready = 1'b1;
    step();
    chk("bp_rel_B",     129'(m_if.tdata), 129'('hB));
    chk("bp_rel_ready", 129'(mod_if.tready), 129'(1));
    step();
    chk("bp_rel_C", 129'(m_if.tdata), 129'('hC));
    drive(1'b0, '0, 1'b0);
    step();
    chk("bp_drain_tvalid", 129'(m_if.tvalid), 129'(0));
    chk("bp_fc", 129'(fc), 129'(1));

    // Reset mid-stream with two beats buffered
    m_if.tready = 1'b0;
    drive(1'b1, W'('h51), 1'b1);
    step();
    drive(1'b1, W'('h52), 1'b1);
    step();
    drive(1'b0, '0, 1'b0);
    chk("mid_ready_full", 129'(mod_if.tready), 129'(0));
    #2;
    rst_n = 1'b0;
    #1;
    chk("mid_rst_tvalid", 129'(m_if.tvalid), 129'(0));
    chk("mid_rst_fc",     129'(fc), 129'(0));
    chk("mid_rst_tdata",  129'(m_if.tdata), 129'(0));
    #3;
    rst_n = 1'b1;
    m_if.tready = 1'b1;
    #1;
    chk("mid_ready_pre", 129'(mod_if.tready), 129'(0));
    for (int i = 0; i < 3; i++) begin
      step();
      chk("mid_no_ghost", 129'(m_if.tvalid), 129'(0));
    end
    chk("mid_ready_post", 129'(mod_if.tready), 129'(1));

    // Frame counter wrap: 17 single-beat frames
    for (int k = 1; k <= 17; k++) begin
      drive(1'b1, W'(k), 1'b1);
      step();
      if (k == 16) chk("wrap_15", 129'(fc), 129'(15));
      if (k == 17) chk("wrap_0",  129'(fc), 129'(0));
    end
    drive(1'b0, '0, 1'b0);
    step();
    chk("wrap_1", 129'(fc), 129'(1));

    // Random stress with scoreboard and stability checks
    sent = 0; recv = 0; lasts_out = 0; hold = 1'b0; hold_val = '0;
    for (cyc = 0; cyc < 20000 && recv < STRESS_BEATS; cyc++) begin
      drive((sent < STRESS_BEATS) && ($urandom_range(0, 1) == 1), W'(sent), (sent % 5 == 4));
      m_if.tready = ($urandom_range(0, 1) == 1);
      in_f  = mod_if.tvalid && mod_if.tready;
      out_f = m_if.tvalid && m_if.tready;
      if (in_f) begin
        sb.push_back({mod_if.tlast, mod_if.tdata});
        sent++;
      end
      if (out_f) begin
        exp_beat = (sb.size() != 0) ? sb.pop_front() : '1;
        chk("stress_beat", {m_if.tlast, m_if.tdata}, exp_beat);
        recv++;
        if (m_if.tlast) lasts_out++;
      end
      hold     = m_if.tvalid && !m_if.tready;
      hold_val = {m_if.tlast, m_if.tdata};
      step();
      if (hold) begin
        chk("stress_hold_valid", 129'(m_if.tvalid), 129'(1));
        chk("stress_hold_data",  {m_if.tlast, m_if.tdata}, hold_val);
      end
    end
    drive(1'b0, '0, 1'b0);
    chk("stress_count", 129'(recv), 129'(STRESS_BEATS));
    chk("stress_fc", 129'(fc), 129'((1 + lasts_out) % 16));
    step();
    chk("stress_idle", 129'(m_if.tvalid), 129'(0));

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
